// File: rtl/signal_conflict_monitor.sv
// Safety stage between the traffic-light controller and the lamp drivers: it latches the first rule violation and flashes red until a clear and an all-red recovery.
// Optional build macro FAULT_COUNT_EN adds the saturating fault_count output.
module signal_conflict_monitor #(
    parameter int MIN_GREEN    = 25,
    parameter int MIN_YELLOW   = 5,
    parameter int FLASH_HALF   = 1,
    parameter int ALL_RED_TIME = 5,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] north_light,
    input  logic [2:0] west_light,
    input  logic [2:0] south_light,
    input  logic [2:0] east_light,
    input  logic       clear_fault,
    output logic [2:0] north_lamp,
    output logic [2:0] west_lamp,
    output logic [2:0] south_lamp,
    output logic [2:0] east_lamp,
    output logic       fault,
    output logic [2:0] fault_code
`ifdef FAULT_COUNT_EN
    ,
    output logic [7:0] fault_count
`endif
);
    localparam logic [2:0] RED  = 3'b100;
    localparam logic [2:0] YEL  = 3'b010;
    localparam logic [2:0] GRN  = 3'b001;
    localparam logic [2:0] DARK = 3'b000;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {MONITOR, FAULT, RECOVER} state_t;
    state_t state_q, state_d;

    logic [3:0][2:0]       light, prev_q, lamp_q, lamp_d;
    logic [3:0][CNT_W-1:0] run_q, run_d;
    logic [3:0]            armed_q, armed_d;
    logic                  fault_q, fault_d, phase_q, phase_d, clr_arm;
    logic [2:0]            code_q, code_d, code_now, nonred;
    logic [CNT_W-1:0]      flash_q, flash_d, ival_q, ival_d;
    logic                  bad_enc, bad_trans, short_yel, short_grn, all_red;

    assign light = {east_light, south_light, west_light, north_light};

    always_comb begin
        bad_enc   = 1'b0;
        bad_trans = 1'b0;
        short_yel = 1'b0;
        short_grn = 1'b0;
        nonred    = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (light[i] != RED && light[i] != YEL && light[i] != GRN) bad_enc = 1'b1;
            if (light[i] != RED) nonred = nonred + 3'd1;
            if ((prev_q[i] == GRN && light[i] == RED) ||
                (prev_q[i] == RED && light[i] == YEL) ||
                (prev_q[i] == YEL && light[i] == GRN)) bad_trans = 1'b1;
            if (armed_q[i] && prev_q[i] == YEL && light[i] == RED &&
                run_q[i] < CNT_W'(MIN_YELLOW)) short_yel = 1'b1;
            if (armed_q[i] && prev_q[i] == GRN && light[i] == YEL &&
                run_q[i] < CNT_W'(MIN_GREEN)) short_grn = 1'b1;
        end
        all_red = (nonred == 3'd0);
        if (bad_enc)            code_now = 3'd1;
        else if (nonred > 3'd1) code_now = 3'd2;
        else if (bad_trans)     code_now = 3'd3;
        else if (short_yel)     code_now = 3'd4;
        else if (short_grn)     code_now = 3'd5;
        else                    code_now = 3'd0;
    end

    // History tracks the raw controller request in every state, including while faulted.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (light[i] != prev_q[i])   run_d[i] = CNT_W'(1);
            else if (run_q[i] == CNT_MAX) run_d[i] = CNT_MAX;
            else                          run_d[i] = run_q[i] + CNT_W'(1);
            if (clr_arm)                                   armed_d[i] = 1'b0;
            else if (prev_q[i] == RED && light[i] == GRN)  armed_d[i] = 1'b1;
            else                                           armed_d[i] = armed_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        lamp_d  = lamp_q;
        fault_d = fault_q;
        code_d  = code_q;
        phase_d = phase_q;
        flash_d = flash_q;
        ival_d  = ival_q;
        clr_arm = 1'b0;
        case (state_q)
            MONITOR: begin
                if (code_now != 3'd0) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    code_d  = code_now;
                    lamp_d  = {4{RED}};
                    phase_d = 1'b1;
                    flash_d = '0;
                end else begin
                    lamp_d = light;
                end
            end
            FAULT: begin
                if (clear_fault && all_red) begin
                    state_d = RECOVER;
                    lamp_d  = {4{RED}};
                    ival_d  = '0;
                end else begin
                    if (flash_q == CNT_W'(FLASH_HALF - 1)) begin
                        phase_d = ~phase_q;
                        flash_d = '0;
                    end else begin
                        flash_d = flash_q + CNT_W'(1);
                    end
                    lamp_d = phase_d ? {4{RED}} : {4{DARK}};
                end
            end
            RECOVER: begin
                if (code_now == 3'd1 || code_now == 3'd2) begin
                    state_d = FAULT;
                    code_d  = code_now;
                    lamp_d  = {4{RED}};
                    phase_d = 1'b1;
                    flash_d = '0;
                end else if (ival_q == CNT_W'(ALL_RED_TIME - 1)) begin
                    state_d = MONITOR;
                    fault_d = 1'b0;
                    code_d  = 3'd0;
                    lamp_d  = light;
                    clr_arm = 1'b1;
                end else begin
                    ival_d = ival_q + CNT_W'(1);
                end
            end
            default: state_d = MONITOR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MONITOR;
            prev_q  <= {4{RED}};
            lamp_q  <= {4{RED}};
            run_q   <= '0;
            armed_q <= '0;
            fault_q <= 1'b0;
            code_q  <= 3'd0;
            phase_q <= 1'b1;
            flash_q <= '0;
            ival_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= light;
            lamp_q  <= lamp_d;
            run_q   <= run_d;
            armed_q <= armed_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            phase_q <= phase_d;
            flash_q <= flash_d;
            ival_q  <= ival_d;
        end
    end

`ifdef FAULT_COUNT_EN
    logic [7:0] fcnt_q;
    logic       enter_fault;
    assign enter_fault = (state_d == FAULT) && (state_q != FAULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                fcnt_q <= 8'd0;
        else if (enter_fault && fcnt_q != 8'hFF) fcnt_q <= fcnt_q + 8'd1;
    end
    assign fault_count = fcnt_q;
`endif

    assign north_lamp = lamp_q[0];
    assign west_lamp  = lamp_q[1];
    assign south_lamp = lamp_q[2];
    assign east_lamp  = lamp_q[3];
    assign fault      = fault_q;
    assign fault_code = code_q;
endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed bench for signal_conflict_monitor with a rule-level reference model checked every cycle.
module tb_signal_conflict_monitor;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, D = 3'b000;
    localparam int MIN_GREEN = 25, MIN_YELLOW = 5, FLASH_HALF = 1, ALL_RED_TIME = 5;

    logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
    logic [2:0] nl = R, wl = R, sl = R, el = R;
    logic [2:0] n_lamp, w_lamp, s_lamp, e_lamp, fcode;
    logic fault;
`ifdef FAULT_COUNT_EN
    logic [7:0] fcount;
`endif
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    signal_conflict_monitor #(
        .MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW), .FLASH_HALF(FLASH_HALF),
        .ALL_RED_TIME(ALL_RED_TIME), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .north_light(nl), .west_light(wl), .south_light(sl), .east_light(el),
        .clear_fault(clr),
        .north_lamp(n_lamp), .west_lamp(w_lamp), .south_lamp(s_lamp), .east_lamp(e_lamp),
        .fault(fault), .fault_code(fcode)
`ifdef FAULT_COUNT_EN
        , .fault_count(fcount)
`endif
    );

    // Reference model: state 0 monitor, 1 fault, 2 recover; m_age counts edges since entering the state.
    int         m_state, m_age, m_code, m_fc;
    bit         m_fault;
    logic [2:0] m_prev [4];
    logic [2:0] m_lamp [4];
    int         m_run  [4];
    bit         m_armed[4];

    function automatic bit is_color(input logic [2:0] x);
        return (x == R) || (x == Y) || (x == G);
    endfunction

    function automatic logic [2:0] follows(input logic [2:0] x);
        case (x)
            R:       return G;
            G:       return Y;
            default: return R;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_age = 0; m_code = 0; m_fc = 0; m_fault = 0;
        for (int i = 0; i < 4; i++) begin
            m_prev[i] = R; m_lamp[i] = R; m_run[i] = 0; m_armed[i] = 0;
        end
    endtask

    task automatic enter_fault(input int c);
        m_state = 1; m_fault = 1; m_code = c; m_age = 0;
        m_fc = (m_fc < 255) ? m_fc + 1 : 255;
        for (int i = 0; i < 4; i++) m_lamp[i] = R;
    endtask

    task automatic model_step();
        logic [2:0] cur[4];
        int  code, nonred;
        bit  enc_bad, seq_bad, y_short, g_short, to_monitor;
        cur = '{nl, wl, sl, el};
        nonred = 0; enc_bad = 0; seq_bad = 0; y_short = 0; g_short = 0; to_monitor = 0;
        for (int i = 0; i < 4; i++) begin
            if (!is_color(cur[i])) enc_bad = 1;
            if (cur[i] != R) nonred++;
            if (is_color(cur[i]) && is_color(m_prev[i]) && cur[i] != m_prev[i] &&
                cur[i] != follows(m_prev[i])) seq_bad = 1;
            if (m_armed[i] && m_prev[i] == Y && cur[i] == R && m_run[i] < MIN_YELLOW) y_short = 1;
            if (m_armed[i] && m_prev[i] == G && cur[i] == Y && m_run[i] < MIN_GREEN) g_short = 1;
        end
        code = enc_bad ? 1 : (nonred > 1) ? 2 : seq_bad ? 3 : y_short ? 4 : g_short ? 5 : 0;
        case (m_state)
            0: if (code != 0) enter_fault(code);
               else for (int i = 0; i < 4; i++) m_lamp[i] = cur[i];
            1: if (clr && nonred == 0) begin
                   m_state = 2; m_age = 0;
                   for (int i = 0; i < 4; i++) m_lamp[i] = R;
               end else begin
                   m_age++;
                   for (int i = 0; i < 4; i++) m_lamp[i] = ((m_age / FLASH_HALF) % 2 == 0) ? R : D;
               end
            default: if (code == 1 || code == 2) enter_fault(code);
               else begin
                   m_age++;
                   if (m_age == ALL_RED_TIME) begin
                       m_state = 0; m_fault = 0; m_code = 0; to_monitor = 1;
                       for (int i = 0; i < 4; i++) m_lamp[i] = cur[i];
                   end
               end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (m_prev[i] == R && cur[i] == G) m_armed[i] = 1;
            if (to_monitor) m_armed[i] = 0;
            m_run[i]  = (cur[i] != m_prev[i]) ? 1 : ((m_run[i] < 255) ? m_run[i] + 1 : 255);
            m_prev[i] = cur[i];
        end
    endtask

    task automatic check_outputs();
        logic [15:0] act, exp;
        logic [2:0]  mc;
        mc  = m_code[2:0];
        act = {n_lamp, w_lamp, s_lamp, e_lamp, fault, fcode};
        exp = {m_lamp[0], m_lamp[1], m_lamp[2], m_lamp[3], m_fault, mc};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, act, exp);
        end
`ifdef FAULT_COUNT_EN
        checks++;
        if (int'(fcount) != m_fc) begin
            failures++;
            $display("FAIL cycle_fault_count t=%0t got=%0d expected=%0d", $time, fcount, m_fc);
        end
`endif
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] n, input logic [2:0] w, input logic [2:0] s,
                        input logic [2:0] e, input logic c);
        nl = n; wl = w; sl = s; el = e; clr = c;
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic step_rep(input logic [2:0] n, input logic [2:0] w, input logic [2:0] s,
                            input logic [2:0] e, input int cnt);
        for (int k = 0; k < cnt; k++) step(n, w, s, e, 1'b0);
    endtask

    initial begin
        logic [2:0] v[4];
        model_reset();
        #12;
        check_outputs();
        chk("reset_lamp", int'(n_lamp), 4);
        chk("reset_fault", int'({fault, fcode}), 0);
        rst = 1'b0;

        // Two controller-shaped rounds N, W, S, E
        for (int r = 0; r < 2; r++)
            for (int a = 0; a < 4; a++) begin
                v = '{R, R, R, R}; v[a] = G;
                step_rep(v[0], v[1], v[2], v[3], 25);
                v[a] = Y;
                step_rep(v[0], v[1], v[2], v[3], 5);
            end
        step(R, R, R, R, 1'b0);
        chk("legal_no_fault", int'({fault, fcode}), 0);
        chk("legal_lamp_red", int'(e_lamp), 4);

        // Conflict during north green
        step_rep(G, R, R, R, 10);
        chk("pass_through_green", int'(n_lamp), 1);
        step(G, R, R, G, 1'b0);
        chk("conflict_code", int'({fault, fcode}), 10);
        chk("conflict_lamp_on", int'(n_lamp), 4);
        step(G, R, R, R, 1'b0);
        chk("flash_off", int'(e_lamp), 0);
        step(G, R, R, R, 1'b0);
        chk("flash_on", int'(w_lamp), 4);
        step(G, R, R, R, 1'b1);
        chk("clear_ignored", int'({fault, fcode}), 10);
        step_rep(Y, R, R, R, 5);
        step_rep(R, R, R, R, 2);
        step(R, R, R, R, 1'b1);
        chk("recover_lamp", int'(s_lamp), 4);
        step_rep(R, R, R, R, 2);
        step_rep(R, G, R, R, 2);
        chk("recover_still_fault", int'({fault, fcode}), 10);
        step(R, G, R, R, 1'b0);
        chk("recovered", int'({fault, fcode}), 0);
        // Partial green started in recovery is unarmed: short green and short yellow pass
        step_rep(R, G, R, R, 3);
        step_rep(R, Y, R, R, 2);
        step(R, R, R, R, 1'b0);
        chk("unarmed_no_fault", int'(fault), 0);

        // Armed north with short yellow
        step_rep(G, R, R, R, 25);
        step_rep(Y, R, R, R, 3);
        step(R, R, R, R, 1'b0);
        chk("short_yellow_code", int'({fault, fcode}), 12);
        step_rep(R, R, R, R, 2);
        step(R, R, R, R, 1'b1);
        step_rep(R, R, R, R, 5);
        chk("recovered_2", int'(fault), 0);

        // Illegal encoding beats conflict
        step_rep(R, R, G, R, 25);
        step(R, 3'b011, Y, R, 1'b0);
        chk("encoding_priority", int'(fcode), 1);
        step(R, R, R, R, 1'b0);
        chk("off_phase_before_reset", int'(n_lamp), 0);
`ifdef FAULT_COUNT_EN
        chk("fault_count_3", int'(fcount), 3);
`endif
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        chk("async_reset_lamp", int'(n_lamp), 4);
        chk("async_reset_fault", int'({fault, fcode}), 0);
`ifdef FAULT_COUNT_EN
        chk("async_reset_count", int'(fcount), 0);
`endif
        #2;
        rst = 1'b0;

        // Armed short green
        step_rep(R, R, R, R, 2);
        step_rep(G, R, R, R, 10);
        step(Y, R, R, R, 1'b0);
        chk("short_green_code", int'({fault, fcode}), 13);
        step_rep(R, R, R, R, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
